// File: rtl/gesture_cond_pkg.sv
// Shared types and helpers for the gesture input conditioner.
// The optional event counter is enabled with GESTURE_COND_EVT_CNT_EN.
package gesture_cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HOLD    = 2'd2,
        REARM   = 2'd3
    } state_t;

    localparam int EVT_CNT_W = 8;

    // Counter width wide enough to hold the larger of two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a parameterised reset level.
// Used on every asynchronous board input.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gesture_in_conditioner.sv
// Debounces the gesture-sensor interrupt pin and emits one fixed-width pulse per event.
// Define GESTURE_COND_EVT_CNT_EN to add the 8-bit evt_count output.
module gesture_in_conditioner
    import gesture_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 2500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 raw_in,
    output logic                 gesture_out,
    output logic                 busy
`ifdef GESTURE_COND_EVT_CNT_EN
    ,
    output logic [EVT_CNT_W-1:0] evt_count
`endif
);

    localparam int               CNT_W     = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync_out;
    logic             act;
    logic             qualify_done;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_out)
    );

    // act is 1 whenever the sensor is asserting, regardless of pin polarity.
    assign act          = sync_out ^ ACTIVE_LOW;
    assign qualify_done = (state == QUALIFY) && act && (cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (act) begin
                        state <= QUALIFY;
                        cnt   <= '0;
                    end
                end
                QUALIFY: begin
                    if (!act) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                // The pin is deliberately ignored while the pulse is being held.
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= REARM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REARM: begin
                    if (act) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign gesture_out = (state == HOLD);
    assign busy        = (state != IDLE);

`ifdef GESTURE_COND_EVT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_count <= '0;
        end else if (qualify_done) begin
            evt_count <= evt_count + EVT_CNT_W'(1);
        end
    end
`endif

endmodule
